if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch front end for the 5-stage MIPS pipeline.
- Owns the PC and fetches from a variable-latency instruction memory with a req/ready handshake.
- Loads the IF/ID register whose opcode/func fields feed the control unit, and applies the PCsrc redirect the control unit returns.
- Handles load-use stalls with a one-entry skid buffer. Handles branch/jump flushes, including a redirect that arrives while a memory request is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000: PC after reset.
- NOP_INST, 32'h0000_0000: instruction word loaded into IF/ID on flush or bubble.

Ports:
- clk  in  1  pipeline clock; only clock.
- rst  in  1  asynchronous, active-high reset.
- PCsrc  in  2  from control unit: 0 = sequential, 1 = branch taken, 2 = jump, 3 = treated as 0.
- branchAddr  in  32  branch target computed in ID.
- jumpIndex  in  26  instruction[25:0] of the ID instruction.
- stall  in  1  hazard-unit hold of IF/ID and PC.
- imemReq  out  1  fetch request.
- imemAddr  out  32  fetch address; held stable while imemReq=1 and imemReady=0.
- imemReady  in  1  imemData valid this cycle; completes the request.
- imemData  in  32  instruction word.
- inst  out  32  IF/ID instruction.
- pcPlus4  out  32  IF/ID PC+4.
- valid  out  1  IF/ID holds a real instruction.
- opcode  out  6  inst[31:26].
- func  out  6  inst[5:0].

Behaviour:
- Reset (async, rst=1):
  - state=FETCH, pc=RESET_PC.
  - inst=NOP_INST, pcPlus4=0, valid=0.
  - skid empty, redirectPc=0.
  - imemReq forced 0 while rst=1.
  - First request (imemAddr=RESET_PC) is issued in the first cycle after rst falls.
- Redirect:
  - A redirect is taken only when valid=1, stall=0 and PCsrc is 1 or 2.
  - PCsrc=1: target = branchAddr.
  - PCsrc=2: target = {pcPlus4[31:28], jumpIndex, 2'b00}.
  - A taken redirect flushes IF/ID next edge: inst=NOP_INST, valid=0.
- Priority each edge: rst > stall > redirect > normal fetch.
  - While stall=1, PCsrc is ignored: the ID instruction is re-evaluated after the stall.
- imemReq is 1 in FETCH and DISCARD, 0 in HOLD.
- imemAddr = pc in FETCH and DISCARD.
- FSM, state FETCH:
  - ready=1, no stall, no redirect: IF/ID<=imemData, pcPlus4<=pc+4, valid<=1, pc<=pc+4.
  - ready=1, stall=1: skid<=imemData, skidPc4<=pc+4, pc<=pc+4, IF/ID held, go to HOLD.
  - ready=1, redirect: drop data, pc<=target, IF/ID flushed, stay in FETCH.
  - ready=0, redirect: redirectPc<=target, IF/ID flushed, go to DISCARD. pc is unchanged so imemAddr stays stable.
  - ready=0, stall=1: IF/ID held.
  - ready=0, otherwise: IF/ID<=bubble (NOP_INST, valid=0).
- FSM, state DISCARD:
  - A further redirect overwrites redirectPc (newest wins).
  - ready=1: drop data, pc<=redirectPc, go to FETCH.
  - IF/ID gets a bubble unless stall=1.
- FSM, state HOLD:
  - stall=1: everything held.
  - stall=0, no redirect: IF/ID<=skid, pcPlus4<=skidPc4, valid<=1, go to FETCH.
  - stall=0, redirect: skid dropped, pc<=target, IF/ID flushed, go to FETCH.
- Arithmetic: PC+4 wraps mod 2^32. No alignment checks; the low two bits pass through.
- Reset mid-request: the outstanding request is abandoned. A stale imemReady in the first post-reset cycle counts as completing the RESET_PC request; the memory must not assert ready while imemReq=0.

Decomposition:
- Shared package mips_pkg:
  - PCsrc encodings PC_SEQ=2'd0, PC_BR=2'd1, PC_J=2'd2.
  - Opcode/func constants shared with the control unit.
  - NOP_INST.
  - if_state_t enum {FETCH, DISCARD, HOLD}.
- One natural sub-module, if_skid_buf: a one-entry buffer of {inst, pcPlus4} with load/unload/clear. All other logic stays in if_stage.

Test Plan:
- Reset release with single-cycle ready memory: addresses 0, 4, 8 are requested on consecutive cycles. IF/ID shows the words with pcPlus4 = 4, 8, 12 and valid=1 from the second cycle.
- Taken branch: PCsrc=1, branchAddr=0x40 with valid=1. The next edge gives valid=0 and inst=0, and the following request address is 0x40.
- Jump: IF/ID pcPlus4=0x1000_0010, jumpIndex=0x0000010, PCsrc=2. Next imemAddr=0x1000_0040.
- Stall during completion: stall=1 in the cycle ready=1 for addr 8. State goes to HOLD with imemReq=0 and IF/ID unchanged. When stall drops, IF/ID gets the addr-8 word, then a request goes out to 12.
- Redirect with a 3-cycle-latency memory: PCsrc=1 to 0x80 in the first wait cycle. imemAddr stays at the old pc until ready, the data is dropped, the next request is 0x80, and no valid instruction appears in between.
- Async reset asserted mid-wait: the outputs clear immediately without a clock edge, and imemReq=0 while rst=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: PC-source encodings, opcode/func fields,
// fetch FSM states and the skid-buffer entry layout.
package mips_pkg;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_J   = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Opcodes decoded by the control unit from IF/ID inst[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes from inst[5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } skid_entry_t;

  // J-type target: upper nibble of the delay-slot PC, 26-bit index, word aligned
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry buffer that catches a fetch completing while IF/ID is stalled.
module if_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc4_o,
  output logic        full_o
);

  skid_entry_t entry_q, entry_d;
  logic        full_q, full_d;

  always_comb begin
    entry_d = entry_q;
    full_d  = full_q;
    if (clear_i || unload_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      entry_d = '{inst: inst_i, pc4: pc4_i};
      full_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      full_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      full_q  <= full_d;
    end
  end

  assign inst_o = entry_q.inst;
  assign pc4_o  = entry_q.pc4;
  assign full_o = full_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks req/ready to imem, loads IF/ID,
// absorbs load-use stalls via a skid entry and handles in-flight redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCsrc,
  input  logic [31:0] branchAddr,
  input  logic [25:0] jumpIndex,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] inst,
  output logic [31:0] pcPlus4,
  output logic        valid,
  output logic [5:0]  opcode,
  output logic [5:0]  func
);
  import mips_pkg::*;

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  logic        skid_load, skid_unload, skid_clear;
  logic [31:0] skid_inst, skid_pc4;
  logic        skid_full;

  // PCsrc is only meaningful for a real, non-stalled ID instruction
  assign redirect = valid_q && !stall && (PCsrc == PC_BR || PCsrc == PC_J);
  assign target   = (PCsrc == PC_J) ? jump_target(pc4_q, jumpIndex) : branchAddr;
  assign pc_inc   = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rpc_d       = rpc_q;
    inst_d      = inst_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    case (state_q)
      FETCH: begin
        if (imemReady) begin
          if (stall) begin
            skid_load = 1'b1;
            pc_d      = pc_inc;
            state_d   = HOLD;
          end else if (redirect) begin
            pc_d    = target;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end else begin
            inst_d  = imemData;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
        end else if (!stall) begin
          // pc stays put on a pending redirect so imemAddr is stable until ready
          if (redirect) begin
            rpc_d   = target;
            state_d = DISCARD;
          end
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end
      end

      DISCARD: begin
        if (redirect) rpc_d = target;
        if (imemReady) begin
          pc_d    = rpc_d;
          state_d = FETCH;
        end
        if (!stall) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (!stall) begin
          state_d = FETCH;
          if (redirect) begin
            skid_clear = 1'b1;
            pc_d       = target;
            inst_d     = NOP_INST;
            valid_d    = 1'b0;
          end else begin
            skid_unload = 1'b1;
            inst_d      = skid_inst;
            pc4_d       = skid_pc4;
            valid_d     = skid_full;
          end
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      rpc_q   <= 32'd0;
      inst_q  <= NOP_INST;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  if_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .inst_i   (imemData),
    .pc4_i    (pc_inc),
    .inst_o   (skid_inst),
    .pc4_o    (skid_pc4),
    .full_o   (skid_full)
  );

  assign imemReq  = !rst && (state_q != HOLD);
  assign imemAddr = pc_q;
  assign inst     = inst_q;
  assign pcPlus4  = pc4_q;
  assign valid    = valid_q;
  assign opcode   = inst_q[31:26];
  assign func     = inst_q[5:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory returns 0xC000_0000 | addr after a
// programmable number of request cycles.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  PCsrc = 2'd0;
  logic [31:0] branchAddr = 32'd0;
  logic [25:0] jumpIndex = 26'd0;
  logic        stall = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] inst;
  logic [31:0] pcPlus4;
  logic        valid;
  logic [5:0]  opcode;
  logic [5:0]  func;

  int lat = 1;
  int cnt;
  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .PCsrc      (PCsrc),
    .branchAddr (branchAddr),
    .jumpIndex  (jumpIndex),
    .stall      (stall),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemReady  (imemReady),
    .imemData   (imemData),
    .inst       (inst),
    .pcPlus4    (pcPlus4),
    .valid      (valid),
    .opcode     (opcode),
    .func       (func)
  );

  always #5 clk = ~clk;

  assign imemReady = imemReq && (cnt >= lat - 1);
  assign imemData  = 32'hC000_0000 | imemAddr;

  always @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= 0;
    else if (!imemReq || imemReady) cnt <= 0;
    else                            cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tick();
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc4", pcPlus4, 32'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_req", imemReq, 1'b0);
    rst = 1'b0;
    #1;
    chk("first_req", imemReq, 1'b1);
    chk("first_addr", imemAddr, 32'h0);

    // sequential fetch, single-cycle memory
    tick();
    chk("seq0_inst", inst, 32'hC000_0000);
    chk("seq0_pc4", pcPlus4, 32'h4);
    chk("seq0_valid", valid, 1'b1);
    chk("seq0_addr", imemAddr, 32'h4);
    tick();
    chk("seq1_inst", inst, 32'hC000_0004);
    chk("seq1_pc4", pcPlus4, 32'h8);
    chk("seq1_addr", imemAddr, 32'h8);
    chk("seq1_opcode", opcode, 6'h30);
    chk("seq1_func", func, 6'h04);

    // taken branch to 0x40
    PCsrc = 2'd1; branchAddr = 32'h40;
    tick();
    chk("br_valid", valid, 1'b0);
    chk("br_inst", inst, 32'h0);
    chk("br_addr", imemAddr, 32'h40);
    PCsrc = 2'd0;
    tick();
    chk("br_tgt_inst", inst, 32'hC000_0040);
    chk("br_tgt_pc4", pcPlus4, 32'h44);

    // branch to 0x1000_000C so pcPlus4 becomes 0x1000_0010, then jump
    PCsrc = 2'd1; branchAddr = 32'h1000_000C;
    tick();
    PCsrc = 2'd0;
    tick();
    chk("pre_j_pc4", pcPlus4, 32'h1000_0010);
    chk("pre_j_inst", inst, 32'hD000_000C);
    PCsrc = 2'd2; jumpIndex = 26'h000_0010;
    tick();
    chk("j_addr", imemAddr, 32'h1000_0040);
    chk("j_valid", valid, 1'b0);
    PCsrc = 2'd0;
    tick();
    chk("j_tgt_inst", inst, 32'hD000_0040);

    // PCsrc=3 behaves as sequential
    PCsrc = 2'd3; branchAddr = 32'h300;
    tick();
    chk("pc3_inst", inst, 32'hD000_0044);
    chk("pc3_pc4", pcPlus4, 32'h1000_0048);
    chk("pc3_addr", imemAddr, 32'h1000_0048);
    PCsrc = 2'd0;

    // stall while addr 8 completes
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    tick();
    chk("st_pre_addr", imemAddr, 32'h8);
    stall = 1'b1;
    tick();
    chk("st_req", imemReq, 1'b0);
    chk("st_inst", inst, 32'hC000_0004);
    chk("st_pc4", pcPlus4, 32'h8);
    chk("st_valid", valid, 1'b1);
    // PCsrc must be ignored while stalled
    PCsrc = 2'd1; branchAddr = 32'h200;
    tick();
    chk("st2_inst", inst, 32'hC000_0004);
    chk("st2_req", imemReq, 1'b0);
    PCsrc = 2'd0; stall = 1'b0;
    tick();
    chk("unst_inst", inst, 32'hC000_0008);
    chk("unst_pc4", pcPlus4, 32'hC);
    chk("unst_valid", valid, 1'b1);
    chk("unst_req", imemReq, 1'b1);
    chk("unst_addr", imemAddr, 32'hC);
    tick();
    chk("post_inst", inst, 32'hC000_000C);

    // redirect while a 3-cycle request is outstanding
    lat = 3;
    PCsrc = 2'd1; branchAddr = 32'h80;
    tick();
    chk("dsc_valid", valid, 1'b0);
    chk("dsc_inst", inst, 32'h0);
    chk("dsc_addr", imemAddr, 32'h10);
    chk("dsc_req", imemReq, 1'b1);
    PCsrc = 2'd0;
    tick();
    chk("dsc2_addr", imemAddr, 32'h10);
    chk("dsc2_valid", valid, 1'b0);
    tick();
    chk("dsc3_addr", imemAddr, 32'h80);
    chk("dsc3_valid", valid, 1'b0);
    tick();
    chk("w1_valid", valid, 1'b0);
    tick();
    chk("w2_valid", valid, 1'b0);
    tick();
    chk("tgt80_inst", inst, 32'hC000_0080);
    chk("tgt80_pc4", pcPlus4, 32'h84);
    chk("tgt80_valid", valid, 1'b1);

    // asynchronous reset mid-wait, no clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("arst_inst", inst, 32'h0);
    chk("arst_valid", valid, 1'b0);
    chk("arst_pc4", pcPlus4, 32'h0);
    chk("arst_req", imemReq, 1'b0);
    chk("arst_addr", imemAddr, 32'h0);
    rst = 1'b0;
    #1;
    chk("arst_rel_req", imemReq, 1'b1);
    chk("arst_rel_addr", imemAddr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
